// File: rtl/dps_pkg.sv
// Shared state encoding and saturating position arithmetic for the
// multi-channel MMCM dynamic-phase-shift controller.
package dps_pkg;

   localparam logic S_IDLE = 1'b0;
   localparam logic S_WAIT = 1'b1;

   // Positions are handled sign-extended to 64 bits so one function serves any TOT_W <= 64.
   function automatic logic signed [63:0] sat_inc(input logic signed [63:0] pos,
                                                  input logic              dir,
                                                  input int                tot_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (tot_w - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (dir)
         sat_inc = (pos >= max_v) ? max_v : pos + 64'sd1;
      else
         sat_inc = (pos <= min_v) ? min_v : pos - 64'sd1;
   endfunction

endpackage

// File: rtl/dps_channel.sv
// One phase-shift channel: toggle/locked synchronisers, IDLE/WAIT sequencer,
// psdone timeout, saturating position and sticky error flags.
module dps_channel
   import dps_pkg::*;
#(
   parameter int STEP_W         = 12,
   parameter int TOT_W          = 24,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYC    = 1023,
   parameter int REQUIRE_LOCKED = 0
) (
   input  logic                psclk_i,
   input  logic                rst_i,
   input  logic                toggle_i,
   input  logic [STEP_W-1:0]   steps_i,
   input  logic                locked_i,
   input  logic                psdone_i,
   input  logic                err_clr_i,
   output logic                psen_o,
   output logic                psincdec_o,
   output logic                busy_o,
   output logic                ack_o,
   output logic                timeout_o,
   output logic                overrun_o,
   output logic [TOT_W-1:0]    total_steps_o
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0]  tog_sync_reg;
   logic [SYNC_STAGES-1:0]  lock_sync_reg;
   logic                    tog_dly_reg;

   logic                    state_reg,   state_next;
   logic                    dir_reg,     dir_next;
   logic [STEP_W-1:0]       rem_reg,     rem_next;
   logic [TMR_W-1:0]        timer_reg,   timer_next;
   logic signed [TOT_W-1:0] pos_reg,     pos_next;
   logic                    psen_reg,    psen_next;
   logic                    ack_reg,     ack_next;
   logic                    timeout_reg, timeout_next;
   logic                    overrun_reg, overrun_next;

   logic                    cmd;
   logic                    locked_s;
   logic                    gate_ok;
   logic                    psdone_ok;
   logic                    last_step;
   logic                    lock_abort;
   logic                    timer_exp;
   logic [STEP_W-1:0]       steps_mag;

   assign cmd        = tog_sync_reg[SYNC_STAGES-1] ^ tog_dly_reg;
   assign locked_s   = lock_sync_reg[SYNC_STAGES-1];
   assign gate_ok    = (REQUIRE_LOCKED == 0) || locked_s;
   // A psdone coincident with our own psen cannot answer it; ignoring it keeps psen pulses apart.
   assign psdone_ok  = psdone_i && !psen_reg;
   assign last_step  = (rem_reg == STEP_W'(1));
   assign lock_abort = (REQUIRE_LOCKED != 0) && !locked_s;
   assign timer_exp  = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
   // Two's-complement negation also maps the most-negative count onto 2^(STEP_W-1) unsigned.
   assign steps_mag  = steps_i[STEP_W-1] ? -steps_i : steps_i;

   always_ff @(posedge psclk_i or posedge rst_i) begin
      if (rst_i) begin
         tog_sync_reg  <= '0;
         lock_sync_reg <= '0;
         tog_dly_reg   <= 1'b0;
         state_reg     <= S_IDLE;
         dir_reg       <= 1'b0;
         rem_reg       <= '0;
         timer_reg     <= '0;
         pos_reg       <= '0;
         psen_reg      <= 1'b0;
         ack_reg       <= 1'b0;
         timeout_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         tog_sync_reg  <= {tog_sync_reg[SYNC_STAGES-2:0], toggle_i};
         lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], locked_i};
         tog_dly_reg   <= tog_sync_reg[SYNC_STAGES-1];
         state_reg     <= state_next;
         dir_reg       <= dir_next;
         rem_reg       <= rem_next;
         timer_reg     <= timer_next;
         pos_reg       <= pos_next;
         psen_reg      <= psen_next;
         ack_reg       <= ack_next;
         timeout_reg   <= timeout_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (cmd && gate_ok && (steps_i != '0))
               state_next = S_WAIT;
         end
         default: begin
            if (psdone_ok) begin
               if (last_step || lock_abort)
                  state_next = S_IDLE;
            end else if (timer_exp) begin
               state_next = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      logic timeout_set;
      logic overrun_set;
      dir_next    = dir_reg;
      rem_next    = rem_reg;
      timer_next  = timer_reg;
      pos_next    = pos_reg;
      psen_next   = 1'b0;
      ack_next    = ack_reg;
      timeout_set = 1'b0;
      overrun_set = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (cmd && gate_ok) begin
               if (steps_i == '0) begin
                  ack_next = ~ack_reg;
               end else begin
                  dir_next   = ~steps_i[STEP_W-1];
                  rem_next   = steps_mag;
                  psen_next  = 1'b1;
                  timer_next = '0;
               end
            end
         end
         default: begin
            overrun_set = cmd;
            timer_next  = timer_reg + TMR_W'(1);
            if (psdone_ok) begin
               pos_next   = TOT_W'(sat_inc(64'(pos_reg), dir_reg, TOT_W));
               timer_next = '0;
               if (last_step || lock_abort) begin
                  ack_next = ~ack_reg;
                  rem_next = '0;
               end else begin
                  rem_next  = rem_reg - STEP_W'(1);
                  psen_next = 1'b1;
               end
            end else if (timer_exp) begin
               timeout_set = 1'b1;
               ack_next    = ~ack_reg;
               rem_next    = '0;
               timer_next  = '0;
            end
         end
      endcase
      // Flag set takes priority over a simultaneous clear.
      timeout_next = timeout_set | (timeout_reg & ~err_clr_i);
      overrun_next = overrun_set | (overrun_reg & ~err_clr_i);
   end

   assign psen_o        = psen_reg;
   assign psincdec_o    = dir_reg;
   assign busy_o        = (state_reg == S_WAIT);
   assign ack_o         = ack_reg;
   assign timeout_o     = timeout_reg;
   assign overrun_o     = overrun_reg;
   assign total_steps_o = pos_reg;

endmodule

// File: rtl/dps_multi_controller.sv
// NCH independent MMCM dynamic-phase-shift sequencers sharing one psclk domain;
// each channel slices its own fields out of the packed buses.
module dps_multi_controller
   import dps_pkg::*;
#(
   parameter int NCH            = 2,
   parameter int STEP_W         = 12,
   parameter int TOT_W          = 24,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYC    = 1023,
   parameter int REQUIRE_LOCKED = 0
) (
   input  logic                  psclk_i,
   input  logic                  rst_i,
   input  logic [NCH-1:0]        toggle_i,
   input  logic [NCH*STEP_W-1:0] steps_i,
   input  logic [NCH-1:0]        locked_i,
   input  logic [NCH-1:0]        psdone_i,
   input  logic [NCH-1:0]        err_clr_i,
   output logic [NCH-1:0]        psen_o,
   output logic [NCH-1:0]        psincdec_o,
   output logic [NCH-1:0]        busy_o,
   output logic [NCH-1:0]        ack_o,
   output logic [NCH-1:0]        timeout_o,
   output logic [NCH-1:0]        overrun_o,
   output logic [NCH*TOT_W-1:0]  total_steps_o
);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         dps_channel #(
            .STEP_W         (STEP_W),
            .TOT_W          (TOT_W),
            .SYNC_STAGES    (SYNC_STAGES),
            .TIMEOUT_CYC    (TIMEOUT_CYC),
            .REQUIRE_LOCKED (REQUIRE_LOCKED)
         ) u_ch (
            .psclk_i       (psclk_i),
            .rst_i         (rst_i),
            .toggle_i      (toggle_i[gi]),
            .steps_i       (steps_i[gi*STEP_W +: STEP_W]),
            .locked_i      (locked_i[gi]),
            .psdone_i      (psdone_i[gi]),
            .err_clr_i     (err_clr_i[gi]),
            .psen_o        (psen_o[gi]),
            .psincdec_o    (psincdec_o[gi]),
            .busy_o        (busy_o[gi]),
            .ack_o         (ack_o[gi]),
            .timeout_o     (timeout_o[gi]),
            .overrun_o     (overrun_o[gi]),
            .total_steps_o (total_steps_o[gi*TOT_W +: TOT_W])
         );
      end
   endgenerate

endmodule
